rat_intr_ctrl: RTL
==================

# rat_intr_ctrl

Interrupt controller that sits directly upstream of the RAT control unit and drives its `INTR` input. It synchronizes up to four external interrupt lines and edge-detects them into pending latches. It gates those latches with a software mask and the CPU interrupt-enable flag. It tracks the interrupt request, acknowledge and service sequence so that exactly one `INTR` request is presented per serviced event. Mask and pending status are accessible through the CPU `IN`/`OUT` port space.

## Interface
- `NUM_SRC`, 4: number of interrupt sources; legal range 1..4.
- `MASK_PORT`, 8'h20: port ID of the mask register (read/write).
- `STAT_PORT`, 8'h21: port ID of the status register (read; write-1-to-clear on pending bits).
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `IRQ_IN`  in  NUM_SRC  raw asynchronous interrupt lines; the rising edge is the event.
- `I_SET`  in  1  from control unit; sets the I flag (`SEI`, `RETIE`).
- `I_CLR`  in  1  from control unit; clears the I flag (`CLI`, `RETID`, interrupt state).
- `INTR_ACK`  in  1  wired to control unit `FLG_SHAD_LD`; high for exactly one cycle in the interrupt state.
- `IO_STRB`  in  1  output strobe from control unit.
- `PORT_ID`  in  8  I/O port address.
- `OUT_PORT`  in  8  CPU output data.
- `IN_DATA`  out  8  read data for the `IN` mux; combinational from registers.
- `RD_HIT`  out  1  high when `PORT_ID` equals `MASK_PORT` or `STAT_PORT`.
- `INTR`  out  1  interrupt request to the control unit; registered.
- `I_FLAG`  out  1  CPU interrupt-enable flag.
- `ACTIVE_ID`  out  2  index of the source currently or last serviced.

## Operation
- Synchronizer: 2 flip-flop stages per source. An edge register holds the previous synchronized value. Edge = sync2 & ~prev.
- Pending[i]: set on edge[i]. Cleared on a `STAT_PORT` write when `OUT_PORT[i]`=1. Cleared when its source is acknowledged. If set and clear occur in the same cycle, set wins, so no event is lost.
- Mask: a write with `IO_STRB`=1 and `PORT_ID`=`MASK_PORT` loads `mask <= OUT_PORT[NUM_SRC-1:0]`. A mask bit of 1 enables the source. Mask bits do not affect pending capture.
- I flag: `I_CLR` has priority over `I_SET`. Otherwise `I_SET` sets the flag; otherwise it holds.
- `req` = `I_FLAG` & |(pending & mask). Both operands are register outputs.
- FSM states:
  - `ST_IDLE` goes to `ST_REQ` when `req`=1.
  - `ST_REQ` goes to `ST_SERVICE` on `INTR_ACK`. It returns to `ST_IDLE` if `req` drops before ack (masked, cleared, or `I_CLR`).
  - `ST_SERVICE` goes to `ST_IDLE` on `I_SET` (`RETIE`/`SEI`), or on `I_CLR` outside an ack cycle (`RETID`).
- `INTR` = 1 exactly while in `ST_REQ`.
- On `INTR_ACK` in `ST_REQ`: `ACTIVE_ID` latches the lowest-index pending & enabled source, and that source's pending bit clears. `INTR_ACK` outside `ST_REQ` is ignored.
- `STAT_PORT` read: [3:0] pending (zero above `NUM_SRC`), [5:4] `ACTIVE_ID`, [6] in-service, [7] `I_FLAG`.
- `MASK_PORT` read: mask, zero-extended.
- `IN_DATA` is 8'h00 when `RD_HIT`=0.

## Timing
- Reset (async assert, sync deassert):
  - Synchronizers, prev, pending and mask are 0.
  - `I_FLAG`=0, `ACTIVE_ID`=0, state `ST_IDLE`, `INTR`=0.
  - `IN_DATA` and `RD_HIT` follow `PORT_ID`.
- Latency from `IRQ_IN` rising before edge k:
  - sync1 at k, sync2 at k+1.
  - Pending set at k+2.
  - `INTR` high after k+3.
- After `INTR_ACK` at edge m, `INTR` is 0 from m onward.
- A further `INTR` needs return to `ST_IDLE`, then one cycle to re-enter `ST_REQ`. Minimum: `I_SET` at edge n gives `INTR` high after n+1.
- A `RESET_N` assertion mid-sequence (any state) returns to `ST_IDLE` immediately. All pending events are discarded.
- A level held high produces one event. A new event needs a low of at least 2 cycles.
- Pulses shorter than 1 `CLK` period may be missed; this is not required to be handled.

## Test plan
- Reset, then `MASK_PORT`←8'h01, `I_SET`, then pulse `IRQ_IN[0]` at edge 10. Required: pending[0]=1 at edge 12, `INTR`=1 after edge 13.
- Ack with `INTR_ACK` at edge 16. Required: `INTR`=0, `ACTIVE_ID`=0, `STAT_PORT` read = 8'h40. Then `I_SET`: state `ST_IDLE`, no second `INTR`.
- Mask=8'h0A, `I_FLAG`=1, raise sources 1 and 3 together. Required: ack gives `ACTIVE_ID`=1. After `RETIE` `I_SET`, `INTR` reasserts; the next ack gives `ACTIVE_ID`=3.
- Masked source 2 fires with mask=0. Required: pending=8'h04, `INTR`=0. Then mask←8'h04: `INTR`=1 within 2 cycles. Then `STAT_PORT`←8'h04 before ack: `INTR` drops and pending=0.
- W1C of pending[0] in the same cycle as a new edge on source 0. Required: pending[0] stays 1. Simultaneous `I_SET` and `I_CLR` leaves `I_FLAG`=0.
- Drive `RESET_N` low in `ST_REQ` and in `ST_SERVICE`. Required: `INTR`=0, mask=0, pending=0 and `I_FLAG`=0 immediately, without a clock edge.

Source files
------------

// File: rtl/rat_intr_ctrl_if.sv
// Control-unit and I/O-port bus between the RAT CPU and its interrupt controller.
// Handshake: INTR is a level request held until the control unit answers with a
// one-cycle INTR_ACK; an INTR_ACK seen while INTR is low carries no meaning and is dropped.
interface rat_intr_ctrl_if;
    logic       I_SET;
    logic       I_CLR;
    logic       INTR_ACK;
    logic       IO_STRB;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic [7:0] IN_DATA;
    logic       RD_HIT;
    logic       INTR;
    logic       I_FLAG;

    modport slave (
        input  I_SET, I_CLR, INTR_ACK, IO_STRB, PORT_ID, OUT_PORT,
        output IN_DATA, RD_HIT, INTR, I_FLAG
    );

    modport master (
        output I_SET, I_CLR, INTR_ACK, IO_STRB, PORT_ID, OUT_PORT,
        input  IN_DATA, RD_HIT, INTR, I_FLAG
    );
endinterface

// File: rtl/rat_intr_ctrl.sv
// Interrupt front end for the RAT control unit: synchronises and edge-captures IRQ lines,
// masks them, and presents exactly one INTR request per serviced event.
module rat_intr_ctrl #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] MASK_PORT = 8'h20,
    parameter logic [7:0] STAT_PORT = 8'h21
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    rat_intr_ctrl_if.slave     bus,
    output logic [1:0]         ACTIVE_ID,
    output logic [1:0]         DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [NUM_SRC-1:0] pending, mask;
    logic [NUM_SRC-1:0] edge_det, enabled, sel_oh, clr_vec;
    logic [1:0]         sel_id;
    logic               sel_any;
    logic               wr_mask, wr_stat, ack_fire, req, i_flag_q;
    logic [7:0]         stat_rd;
    logic               unused_out_port;

    assign edge_det = sync2 & ~prev;
    assign enabled  = pending & mask;
    assign req      = i_flag_q & (|enabled);
    assign wr_mask  = bus.IO_STRB && (bus.PORT_ID == MASK_PORT);
    assign wr_stat  = bus.IO_STRB && (bus.PORT_ID == STAT_PORT);
    assign ack_fire = (state == ST_REQ) && bus.INTR_ACK;

    // Lowest index wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        sel_any = 1'b0;
        sel_id  = 2'd0;
        sel_oh  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                sel_any   = 1'b1;
                sel_id    = 2'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign clr_vec = (wr_stat ? bus.OUT_PORT[NUM_SRC-1:0] : '0)
                   | ((ack_fire && sel_any) ? sel_oh : '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            pending   <= '0;
            mask      <= '0;
            i_flag_q  <= 1'b0;
            ACTIVE_ID <= 2'd0;
            state     <= ST_IDLE;
        end else begin
            sync1   <= IRQ_IN;
            sync2   <= sync1;
            prev    <= sync2;
            // A fresh edge overrides any clear in the same cycle so no event is lost.
            pending <= (pending & ~clr_vec) | edge_det;
            if (wr_mask)
                mask <= bus.OUT_PORT[NUM_SRC-1:0];
            if (bus.I_CLR)
                i_flag_q <= 1'b0;
            else if (bus.I_SET)
                i_flag_q <= 1'b1;
            if (ack_fire && sel_any)
                ACTIVE_ID <= sel_id;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (req) state_nxt = ST_REQ;
            ST_REQ:
                if (bus.INTR_ACK) state_nxt = ST_SERVICE;
                else if (!req)    state_nxt = ST_IDLE;
            ST_SERVICE:
                // I_CLR during the ack cycle is the CPU entering the ISR, not RETID.
                if (bus.I_SET)                          state_nxt = ST_IDLE;
                else if (bus.I_CLR && !bus.INTR_ACK)    state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    assign stat_rd = {i_flag_q, state == ST_SERVICE, ACTIVE_ID, 4'(pending)};

    always_comb begin
        bus.IN_DATA = 8'h00;
        if (bus.PORT_ID == MASK_PORT)
            bus.IN_DATA = 8'(mask);
        else if (bus.PORT_ID == STAT_PORT)
            bus.IN_DATA = stat_rd;
    end

    assign bus.RD_HIT  = (bus.PORT_ID == MASK_PORT) || (bus.PORT_ID == STAT_PORT);
    assign bus.INTR    = (state == ST_REQ);
    assign bus.I_FLAG  = i_flag_q;
    assign DBG_STATE   = state;
    assign unused_out_port = &{1'b0, bus.OUT_PORT};

endmodule
